// File: rtl/pipelined_addsub_if.sv
// Streaming operand/result bundle for pipelined_addsub.
// master = the side that supplies operands and consumes results,
// slave  = the adder/subtractor itself.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor.
// The carry chain is cut into SEG-bit segments, one register stage per
// segment. Each stage adds its segment with the carry registered by the
// previous stage and forwards the operands so later stages can read their
// own segment. Subtract is done as A + ~B + !Cin, with B inverted once on
// entry. The whole pipe advances on En = !OutValid || OutReady.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  // Operand registers feed stages 1..LAST; a single-stage pipe keeps one
  // slot so the arrays never collapse to zero width.
  localparam int OPS    = (STAGES > 1) ? (STAGES - 1) : 1;

  generate
    if ((WIDTH < 2) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of SEG");
    end
  endgenerate

  // Handshake
  logic                         en_s;
  logic                         in_xfer_s;

  // Per-stage combinational view
  logic [WIDTH-1:0]             b_eff_s;
  logic                         cin_eff_s;
  logic [STAGES-1:0][WIDTH-1:0] a_stg_s;
  logic [STAGES-1:0][WIDTH-1:0] b_stg_s;
  logic [STAGES-1:0]            c_stg_s;
  logic [STAGES-1:0][WIDTH-1:0] sum_prev_s;
  logic [STAGES-1:0][SEG:0]     seg_s;
  logic [STAGES-1:0][WIDTH-1:0] sum_nx_s;
  logic                         ovf_nx_s;
  logic                         zero_nx_s;

  // Pipeline state
  logic [STAGES-1:0]            valid_d, valid_q;
  logic [STAGES-1:0]            carry_d, carry_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_d, sum_q;
  logic [OPS-1:0][WIDTH-1:0]    a_d, a_q;
  logic [OPS-1:0][WIDTH-1:0]    b_d, b_q;
  logic                         ovf_d, ovf_q;
  logic                         zero_d, zero_q;

  assign en_s      = !valid_q[LAST] || bus.out_ready;
  assign in_xfer_s = bus.in_valid && en_s;

  assign bus.in_ready  = en_s;
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.carry_out = carry_q[LAST];
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

  // Select what each stage sees: stage 0 takes the conditioned inputs, later stages the previous stage's registers
  always_comb begin
    b_eff_s       = bus.sub ? ~bus.b : bus.b;
    cin_eff_s     = bus.sub ? ~bus.cin : bus.cin;
    a_stg_s[0]    = bus.a;
    b_stg_s[0]    = b_eff_s;
    c_stg_s[0]    = cin_eff_s;
    sum_prev_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_stg_s[k]    = a_q[k-1];
      b_stg_s[k]    = b_q[k-1];
      c_stg_s[k]    = carry_q[k-1];
      sum_prev_s[k] = sum_q[k-1];
    end
  end

  // Segment adders, merged partial sums, and final-stage flags
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_s[k]    = {1'b0, SEG'(a_stg_s[k] >> (k * SEG))}
                  + {1'b0, SEG'(b_stg_s[k] >> (k * SEG))}
                  + {{SEG{1'b0}}, c_stg_s[k]};
      sum_nx_s[k] = sum_prev_s[k] | (WIDTH'(seg_s[k][SEG-1:0]) << (k * SEG));
    end
    // Equal operand signs with a different result sign is exactly
    // carry-into-MSB XOR carry-out-of-MSB.
    ovf_nx_s  = (a_stg_s[LAST][WIDTH-1] == b_stg_s[LAST][WIDTH-1]) &&
                (sum_nx_s[LAST][WIDTH-1] != a_stg_s[LAST][WIDTH-1]);
    zero_nx_s = ~|sum_nx_s[LAST];
  end

  // Next state: shift every slot forward when enabled, otherwise hold everything
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (en_s) begin
      valid_d[0] = in_xfer_s;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        carry_d[k] = seg_s[k][SEG];
        sum_d[k]   = sum_nx_s[k];
      end
      for (int j = 0; j < OPS; j++) begin
        a_d[j] = a_stg_s[j];
        b_d[j] = b_stg_s[j];
      end
      ovf_d  = ovf_nx_s;
      zero_d = zero_nx_s;
    end else begin
      valid_d = valid_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      a_d     = a_q;
      b_d     = b_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
    end
  end

  // Pipeline registers; reset discards all in-flight work
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
endmodule
